alu_operand_sequencer: RTL and testbench

//  Upstream feeder for the 8-bit ALU behind the tt_um top. The 8-bit input bus is too narrow to carry A, B
//  and the opcode at once, so this block loads them one at a time, each on a strobe edge. It then issues
//  one ALU operation and registers the result for uo_out. The ALU itself stays combinational.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/strobe_sync_edge.sv | 36 +++
 rtl/alu_operand_sequencer.sv | 117 +++++++++++
 tb/tb_alu_operand_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, FSM state encoding and opcode constants for the
// ALU operand sequencer and the combinational ALU it feeds.
// No ports. This package holds types and constants only.
package alu_pkg;

   localparam int DATA_W = 8;
   localparam int OP_W   = 3;

   // The state encoding is visible on state_dbg, so the values are fixed.
   typedef enum logic [2:0] {
      ST_LOAD_A  = 3'd0,
      ST_LOAD_B  = 3'd1,
      ST_LOAD_OP = 3'd2,
      ST_EXEC    = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Opcodes that the ALU implements. Other values pass through the
   // sequencer unchanged, and the ALU decides what they do.
   localparam logic [OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB = 3'b001;
   localparam logic [OP_W-1:0] OP_AND = 3'b010;
   localparam logic [OP_W-1:0] OP_OR  = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR = 3'b100;

endpackage

// File: rtl/strobe_sync_edge.sv
// strobe_sync_edge: brings an asynchronous pin into the clk domain through a
// SYNC_STAGES-deep flop chain, then emits a one-cycle pulse on each rising edge.
// The pulse is high SYNC_STAGES clk edges after the pin rises, so a consumer
// that registers on the pulse captures on edge SYNC_STAGES+1.
// Ports:
//   clk    in   system clock
//   rst_n  in   async active-low reset; clears the chain and the edge flop
//   pin    in   asynchronous input pin
//   rise   out  one-cycle pulse per synchronized rising edge
module strobe_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;

   // NOTE: sequential state always uses non-blocking assignments. A shift
   // chain written with blocking assignments would collapse into a single flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: loads A, B and the opcode one at a time from a narrow
// bus, with one load per strobe edge. It then issues a single ALU operation
// and registers the result.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   ena           block enable; low freezes the FSM and all data registers
//   clr           sync clear: FSM to LOAD_A, err_overrun cleared, data kept
//   load_stb      async strobe pin; each rising edge loads data_in
//   data_in       operand/opcode bus
//   alu_a/b/op    registered ALU operands, held stable from capture onward
//   alu_result    combinational ALU result, captured at the end of EXEC
//   alu_start     high for the single EXEC cycle
//   result_out    last captured result
//   result_valid  high in DONE
//   busy          high in LOAD_B, LOAD_OP and EXEC
//   err_overrun   sticky: a strobe edge arrived during EXEC and was dropped
//   state_dbg     current state encoding
module alu_operand_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W      = alu_pkg::DATA_W,
   parameter int OP_W        = alu_pkg::OP_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              clr,
   input  logic              load_stb,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_result,
   output logic              alu_start,
   output logic [DATA_W-1:0] result_out,
   output logic              result_valid,
   output logic              busy,
   output logic              err_overrun,
   output logic [2:0]        state_dbg
);

   state_t state, state_nxt;
   logic   stb_rise;

   // The synchronizer keeps running while ena is low. A pulse that arrives
   // then is not acted on, so it is lost rather than replayed later.
   strobe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stb (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (load_stb),
      .rise  (stb_rise)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   state <= ST_LOAD_A;
      else if (ena) state <= state_nxt;
   end

   // Next-state logic. clr takes priority over a strobe edge in every state.
   // NOTE: every combinational output gets a default before any branch, so
   // that no path leaves it unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = ST_LOAD_A;
      end else begin
         case (state)
            ST_LOAD_A:  if (stb_rise) state_nxt = ST_LOAD_B;
            ST_LOAD_B:  if (stb_rise) state_nxt = ST_LOAD_OP;
            ST_LOAD_OP: if (stb_rise) state_nxt = ST_EXEC;
            ST_EXEC:                  state_nxt = ST_DONE;
            ST_DONE:    if (stb_rise) state_nxt = ST_LOAD_B;
            default:                  state_nxt = ST_LOAD_A;
         endcase
      end
   end

   // Output decode
   always_comb begin
      alu_start    = (state == ST_EXEC);
      result_valid = (state == ST_DONE);
      busy         = (state != ST_LOAD_A) && (state != ST_DONE);
      state_dbg    = state;
   end

   // Operand, result and error registers. Each one changes only on its own
   // capture event, so the ALU inputs stay stable through EXEC.
   // NOTE: these are a few discrete registers rather than a memory array, so
   // they all get the async reset and read as zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
         result_out  <= '0;
         err_overrun <= 1'b0;
      end else if (ena) begin
         if (clr) begin
            err_overrun <= 1'b0;
         end else begin
            case (state)
               ST_LOAD_A, ST_DONE: if (stb_rise) alu_a  <= data_in;
               ST_LOAD_B:          if (stb_rise) alu_b  <= data_in;
               ST_LOAD_OP:         if (stb_rise) alu_op <= data_in[OP_W-1:0];
               ST_EXEC: begin
                  result_out <= alu_result;
                  if (stb_rise) err_overrun <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Testbench for alu_operand_sequencer. It models the ALU behind the
// sequencer, runs the directed corner sequences and a table of operand
// vectors, and then runs random full load/execute sequences. All
// expectations come from the bench's own operation model.
module tb_alu_operand_sequencer;
   import alu_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              ena = 1'b1;
   logic              clr = 1'b0;
   logic              load_stb = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic [DATA_W-1:0] alu_a, alu_b, alu_result, result_out;
   logic [OP_W-1:0]   alu_op;
   logic              alu_start, result_valid, busy, err_overrun;
   logic [2:0]        state_dbg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_operand_sequencer #(.SYNC_STAGES(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .clr          (clr),
      .load_stb     (load_stb),
      .data_in      (data_in),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_result   (alu_result),
      .alu_start    (alu_start),
      .result_out   (result_out),
      .result_valid (result_valid),
      .busy         (busy),
      .err_overrun  (err_overrun),
      .state_dbg    (state_dbg)
   );

   // Reference ALU: plain arithmetic on the opcode meaning.
   function automatic logic [DATA_W-1:0] ref_alu(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [OP_W-1:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return a;
      endcase
   endfunction

   always_comb alu_result = ref_alu(alu_a, alu_b, alu_op);

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Raise the strobe with data and return on the negedge just after the
   // capture edge (pin rise + 3 edges).
   task automatic stb_raise(input logic [DATA_W-1:0] d);
      @(negedge clk);
      data_in  = d;
      load_stb = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic stb_lower();
      load_stb = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic strobe(input logic [DATA_W-1:0] d);
      stb_raise(d);
      stb_lower();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " alu_a"}, alu_a, 0);
      check({tag, " alu_b"}, alu_b, 0);
      check({tag, " alu_op"}, alu_op, 0);
      check({tag, " result_out"}, result_out, 0);
      check({tag, " alu_start"}, alu_start, 0);
      check({tag, " result_valid"}, result_valid, 0);
      check({tag, " busy"}, busy, 0);
      check({tag, " err_overrun"}, err_overrun, 0);
      check({tag, " state"}, state_dbg, 0);
   endtask

   typedef struct {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] op_byte;
      logic [DATA_W-1:0] exp;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{8'hFF, 8'h01, 8'h00, 8'h00};  // add wraps
      vecs[1] = '{8'h00, 8'h01, 8'h01, 8'hFF};  // sub borrows
      vecs[2] = '{8'hF0, 8'h0F, 8'hF8, 8'hFF};  // upper opcode bits ignored -> add
      vecs[3] = '{8'hCC, 8'hAA, 8'h02, 8'h88};  // and
      vecs[4] = '{8'hCC, 8'hAA, 8'h03, 8'hEE};  // or
      vecs[5] = '{8'h5A, 8'h3C, 8'h04, 8'h66};  // xor

      // 1: reset values, and nothing moves without strobes.
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check_all_zero("post_reset");

      // 2: 0x25 + 0x13, with alu_start high for exactly one cycle.
      strobe(8'h25);
      check("t2 busy_after_a", busy, 1);
      strobe(8'h13);
      @(negedge clk);
      data_in  = OP_ADD;
      load_stb = 1'b1;
      repeat (2) @(negedge clk);
      check("t2 no_start_early", alu_start, 0);
      @(negedge clk);
      check("t2 start", alu_start, 1);
      check("t2 state_exec", state_dbg, 3);
      @(negedge clk);
      check("t2 start_one_cycle", alu_start, 0);
      check("t2 result", result_out, 8'h38);
      check("t2 valid", result_valid, 1);
      check("t2 state_done", state_dbg, 4);
      stb_lower();

      // 3: restart from DONE; the old result holds until EXEC ends.
      strobe(8'h10);
      check("t3 restart_state", state_dbg, 1);
      check("t3 restart_a", alu_a, 8'h10);
      check("t3 valid_drop", result_valid, 0);
      check("t3 hold1", result_out, 8'h38);
      strobe(8'h20);
      stb_raise(8'h01);
      check("t3 hold_in_exec", result_out, 8'h38);
      @(negedge clk);
      check("t3 result", result_out, 8'hF0);
      stb_lower();

      // Table of operand vectors
      foreach (vecs[i]) begin
         strobe(vecs[i].a);
         strobe(vecs[i].b);
         strobe(vecs[i].op_byte);
         check($sformatf("vec%0d result", i), result_out, vecs[i].exp);
         check($sformatf("vec%0d op", i), alu_op, vecs[i].op_byte & 8'h07);
         check($sformatf("vec%0d valid", i), result_valid, 1);
      end

      // 4: a strobe edge in EXEC. Freeze in EXEC with ena low, then re-enable
      // on the exact cycle the new edge pulse is present.
      strobe(8'h40);
      strobe(8'h05);
      stb_raise(8'h01);
      ena = 1'b0;
      check("t4 frozen_exec", state_dbg, 3);
      stb_lower();
      data_in  = 8'h77;
      load_stb = 1'b1;
      repeat (2) @(negedge clk);
      ena = 1'b1;
      @(negedge clk);
      check("t4 overrun", err_overrun, 1);
      check("t4 state_done", state_dbg, 4);
      check("t4 result", result_out, 8'h3B);
      stb_lower();
      check("t4 no_capture", alu_a, 8'h40);
      check("t4 overrun_sticky", err_overrun, 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("t4 clr_overrun", err_overrun, 0);
      check("t4 clr_state", state_dbg, 0);
      check("t4 clr_keeps_result", result_out, 8'h3B);

      // 5: ena low in LOAD_B while pulsing the strobe
      strobe(8'h11);
      ena = 1'b0;
      strobe(8'h99);
      check("t5 frozen_state", state_dbg, 1);
      check("t5 b_unchanged", alu_b, 8'h05);
      ena = 1'b1;
      repeat (6) @(negedge clk);
      check("t5 no_stale_state", state_dbg, 1);
      check("t5 no_stale_b", alu_b, 8'h05);

      // 6: async reset in the middle of a cycle while in LOAD_OP
      strobe(8'h22);
      check("t6 in_load_op", state_dbg, 2);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_all_zero("t6 async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      strobe(8'hFF);
      strobe(8'h01);
      strobe(OP_ADD);
      check("t6 result", result_out, 8'h00);
      check("t6 valid", result_valid, 1);

      // Random full sequences with random opcode bytes
      for (int n = 0; n < 24; n++) begin
         logic [DATA_W-1:0] a, b, opb, exp;
         a   = DATA_W'($urandom);
         b   = DATA_W'($urandom);
         opb = DATA_W'($urandom);
         exp = ref_alu(a, b, opb[OP_W-1:0]);
         strobe(a);
         strobe(b);
         strobe(opb);
         check($sformatf("rnd%0d result", n), result_out, exp);
         check($sformatf("rnd%0d a", n), alu_a, a);
         check($sformatf("rnd%0d b", n), alu_b, b);
         check($sformatf("rnd%0d op", n), alu_op, opb[OP_W-1:0]);
         check($sformatf("rnd%0d valid", n), result_valid, 1);
         check($sformatf("rnd%0d busy", n), busy, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
